wb_rr_arbiter: RTL

WB_RR_ARBITER -- requirements
Module: wb_rr_arbiter

---
 rtl/wb_rr_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of a single shared slave.
// Define WB_ARB_TIMEOUT_EN to add a stall watchdog that terminates a hung access with err.
module wb_rr_arbiter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_dat_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    input  logic        m0_cyc_i,
    input  logic        m0_stb_i,
    output logic [31:0] m0_dat_o,
    output logic        m0_ack_o,
    output logic        m0_err_o,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_cyc_i,
    input  logic        m1_stb_i,
    output logic [31:0] m1_dat_o,
    output logic        m1_ack_o,
    output logic        m1_err_o,
    output logic [31:0] s_adr_o,
    output logic [31:0] s_dat_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    output logic        s_cyc_o,
    output logic        s_stb_o,
    input  logic [31:0] s_dat_i,
    input  logic        s_ack_i
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] GNT0 = 2'd1;
    localparam logic [1:0] GNT1 = 2'd2;

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("wb_rr_arbiter: TIMEOUT_CYCLES must be within 2..65535");
    end

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_last_m1;
    logic       w_last_m1_nxt;
    logic       w_req0;
    logic       w_req1;
    logic       w_gnt0;
    logic       w_gnt1;
    logic       w_cyc_g;
    logic       w_stb_g;
    logic       w_to;
    logic       w_live;

    assign w_req0  = m0_cyc_i & m0_stb_i;
    assign w_req1  = m1_cyc_i & m1_stb_i;
    assign w_gnt0  = (r_state == GNT0);
    assign w_gnt1  = (r_state == GNT1);
    assign w_cyc_g = w_gnt1 ? m1_cyc_i : (w_gnt0 & m0_cyc_i);
    assign w_stb_g = w_gnt1 ? m1_stb_i : (w_gnt0 & m0_stb_i);

`ifdef WB_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);
    logic [15:0] r_stall_cnt;

    // Counter is zero whenever a grant starts because it is held clear in IDLE.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || r_state == IDLE || s_ack_i) begin
            r_stall_cnt <= '0;
        end else if (w_stb_g && !w_to) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign w_to     = (w_gnt0 | w_gnt1) & (r_stall_cnt == TO_LIMIT);
    assign m0_err_o = w_gnt0 & w_to & ~wb_rst_i;
    assign m1_err_o = w_gnt1 & w_to & ~wb_rst_i;
`else
    assign w_to     = 1'b0;
    assign m0_err_o = 1'b0;
    assign m1_err_o = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_last_m1_nxt = r_last_m1;
        case (r_state)
            IDLE: begin
                if (w_req0 && (!w_req1 || r_last_m1)) begin
                    w_state_nxt = GNT0;
                end else if (w_req1) begin
                    w_state_nxt = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i || w_to) begin
                    w_state_nxt   = IDLE;
                    w_last_m1_nxt = 1'b0;
                end
            end
            GNT1: begin
                if (!m1_cyc_i || w_to) begin
                    w_state_nxt   = IDLE;
                    w_last_m1_nxt = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= IDLE;
            r_last_m1 <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_last_m1 <= w_last_m1_nxt;
        end
    end

    // Request fields are muxed freely; only cyc/stb and the terminations need qualifying.
    assign w_live   = ~wb_rst_i & ~w_to;
    assign s_adr_o  = w_gnt1 ? m1_adr_i : m0_adr_i;
    assign s_dat_o  = w_gnt1 ? m1_dat_i : m0_dat_i;
    assign s_sel_o  = w_gnt1 ? m1_sel_i : m0_sel_i;
    assign s_we_o   = w_gnt1 ? m1_we_i  : m0_we_i;
    assign s_cyc_o  = w_cyc_g & w_live;
    assign s_stb_o  = w_stb_g & w_live;
    assign m0_ack_o = w_gnt0 & s_ack_i & w_live;
    assign m1_ack_o = w_gnt1 & s_ack_i & w_live;
    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule
